// File: rtl/fnn_pkg.sv
// Shared types and helpers for the feed-forward network weight path.
package fnn_pkg;

  // Sequencer states for the weight fetch engine.
  typedef enum logic [1:0] {
    WF_IDLE  = 2'd0,
    WF_FETCH = 2'd1,
    WF_DRAIN = 2'd2
  } wf_state_t;

  // Weight word, Q-format carried through without interpretation.
  localparam int WF_DATA_W = 16;
  typedef logic [WF_DATA_W-1:0] weight_t;

  // Circular pointer increment for buffers whose depth need not be a power of two.
  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fetch_skid_fifo.sv
// Small synchronous FIFO used as the skid buffer between memory read data and the MAC.
// Simultaneous push and pop is legal at any occupancy, including full.
module fetch_skid_fifo
  import fnn_pkg::*;
#(
  parameter int width = 17,
  parameter int depth = 2,
  parameter int CNT_W = $clog2(depth + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [width-1:0] push_data,
  input  logic             pop,
  output logic [width-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (depth > 1) ? $clog2(depth) : 1;

  logic [width-1:0] storage [depth];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;

  assign do_pop   = pop & ~empty;
  assign full     = (count == CNT_W'(depth));
  assign empty    = (count == '0);
  assign pop_data = storage[rd_ptr];

  // Data array write; entries become visible only through count.
  // NOTE: the storage array has no reset -- the pointers and count define which entries are live,
  // so clearing them is enough and the array stays plain RAM/flops without a reset tree.
  always_ff @(posedge clk) begin
    if (push) storage[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= PTR_W'(wrap_inc(int'(wr_ptr), depth));
      if (do_pop) rd_ptr <= PTR_W'(wrap_inc(int'(rd_ptr), depth));
      case ({push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/weight_fetch_seq.sv
// Weight fetch sequencer: walks a registered-read weight memory from address 0 to
// numWeight-1 and streams the words to the neuron MAC over valid/ready. A read is only
// issued when the skid buffer is guaranteed a free slot for its data, so MAC stalls
// never lose an in-flight word.
module weight_fetch_seq
  import fnn_pkg::*;
#(
  parameter int numWeight    = 30,
  parameter int addressWidth = $clog2(numWeight),
  parameter int dataWidth    = 16,
  parameter int skidDepth    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    mem_ren,
  output logic [addressWidth-1:0] mem_radd,
  input  logic [dataWidth-1:0]    mem_rdata,
  output logic [dataWidth-1:0]    w_data,
  output logic                    w_valid,
  input  logic                    w_ready,
  output logic                    w_last
);

  localparam int CNT_W = $clog2(skidDepth + 1);

  wf_state_t               state;
  logic [addressWidth-1:0] rd_cnt;
  logic                    inflight;
  logic                    inflight_last;
  logic                    at_last;
  logic                    pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [CNT_W-1:0]        fifo_count;
  logic [dataWidth:0]      head;
  logic [CNT_W:0]          pending;
  logic [CNT_W:0]          limit;

  assign at_last  = (rd_cnt == addressWidth'(numWeight - 1));
  assign pop      = w_valid & w_ready;
  assign busy     = (state != WF_IDLE);
  assign mem_radd = rd_cnt;

  // Credit: buffered words plus the word in flight, minus the one leaving now, must stay below depth.
  assign pending = {1'b0, fifo_count} + (CNT_W + 1)'(inflight);
  assign limit   = (CNT_W + 1)'(skidDepth) + (CNT_W + 1)'(pop);
  assign mem_ren = (state == WF_FETCH) && (pending < limit);

  assign w_valid = ~fifo_empty;
  assign {w_last, w_data} = head;

  // Sequencer FSM, read counter, in-flight tracking and completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= WF_IDLE;
      rd_cnt        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      done          <= 1'b0;
    end else begin
      done          <= 1'b0;
      inflight      <= mem_ren;
      inflight_last <= mem_ren & at_last;
      case (state)
        WF_IDLE: begin
          rd_cnt <= '0;
          if (start) state <= WF_FETCH;
        end
        WF_FETCH: begin
          // The counter parks on the last address instead of wrapping.
          if (mem_ren) begin
            if (at_last) state <= WF_DRAIN;
            else         rd_cnt <= rd_cnt + addressWidth'(1);
          end
        end
        WF_DRAIN: begin
          if (pop && w_last) begin
            state  <= WF_IDLE;
            rd_cnt <= '0;
            done   <= 1'b1;
          end
        end
        default: state <= WF_IDLE;
      endcase
    end
  end

  // The credit rule must make a push into a full buffer impossible unless a pop frees a slot.
  always_ff @(posedge clk) begin
    if (!rst) assert (!(inflight && fifo_full && !pop));
  end

  // Memory data is only captured the cycle after a read; otherwise wout is stale.
  fetch_skid_fifo #(
    .width (dataWidth + 1),
    .depth (skidDepth)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data ({inflight_last, mem_rdata}),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_weight_fetch_seq.sv
// Self-checking bench for weight_fetch_seq: registered-read memory model, randomized
// backpressure and a transaction-level reference model (expected word order, busy/done
// timing, outstanding-read credit bound).
module tb_weight_fetch_seq;
  import fnn_pkg::*;

  localparam int NW = 30;
  localparam int AW = $clog2(NW);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy;
  logic          done;
  logic          mem_ren;
  logic [AW-1:0] mem_radd;
  weight_t       mem_rdata = 16'hDEAD;
  weight_t       w_data;
  logic          w_valid;
  logic          w_ready;
  logic          w_last;

  always #5 clk = ~clk;

  weight_fetch_seq #(
    .numWeight (NW),
    .dataWidth (16),
    .skidDepth (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .mem_ren   (mem_ren),
    .mem_radd  (mem_radd),
    .mem_rdata (mem_rdata),
    .w_data    (w_data),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_last    (w_last)
  );

  // Registered-read weight memory, mem[i] = 16'h1000 + i; output holds when not read.
  always @(posedge clk) begin
    if (mem_ren) mem_rdata <= 16'h1000 + 16'(mem_radd);
  end

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: values expected in the cycle currently being sampled.
  int      cyc        = 0;
  bit      m_busy     = 1'b0;
  bit      m_done     = 1'b0;
  int      reads      = 0;   // reads issued in the current run
  int      hs         = 0;   // handshakes completed in the current run
  int      run_start  = 0;
  bit      valid_seen = 1'b1;
  bit      prev_hold  = 1'b0;
  weight_t prev_data  = '0;
  int      done_count = 0;
  int      done_cyc   = 0;
  bit      saw_done   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check settled outputs, advance the model.
  task automatic cycle(input logic rdy, input logic st, input logic rs);
    logic hs_now;
    logic hs_last;
    hs_now  = 1'b0;
    hs_last = 1'b0;
    @(negedge clk);
    w_ready = rdy;
    start   = st;
    rst     = rs;
    #1;
    saw_done = 1'b0;
    if (!rs) begin
      check("busy", busy, m_busy);
      check("done", done, m_done);
      if (!m_busy) begin
        check("ren_idle", mem_ren, 1'b0);
        check("valid_idle", w_valid, 1'b0);
      end
      if (mem_ren) begin
        check("radd", mem_radd, reads);
        check("credit", int'((reads - hs - int'(w_valid & w_ready)) < 2), 1);
        check("read_bound", int'(reads < NW), 1);
      end
      if (prev_hold) begin
        check("hold_valid", w_valid, 1'b1);
        check("hold_data", w_data, prev_data);
      end
      if (w_valid && !valid_seen) begin
        check("latency", cyc - run_start, 3);
        valid_seen = 1'b1;
      end
      hs_now = w_valid & w_ready;
      if (hs_now) begin
        check("data", w_data, 16'h1000 + hs);
        check("last", w_last, int'(hs == NW - 1));
      end
      if (done) begin
        done_count++;
        done_cyc = cyc;
        saw_done = 1'b1;
        check("hs_at_done", hs, NW);
      end
    end
    if (rs) begin
      m_busy     = 1'b0;
      m_done     = 1'b0;
      reads      = 0;
      hs         = 0;
      prev_hold  = 1'b0;
      valid_seen = 1'b1;
    end else begin
      hs_last   = hs_now && (hs == NW - 1);
      m_done    = hs_last;
      prev_hold = w_valid && !w_ready;
      prev_data = w_data;
      if (mem_ren) reads++;
      if (hs_now)  hs++;
      if (m_busy) begin
        if (hs_last) m_busy = 1'b0;
      end else if (st) begin
        m_busy     = 1'b1;
        reads      = 0;
        hs         = 0;
        run_start  = cyc;
        valid_seen = 1'b0;
      end
    end
    cyc++;
  endtask

  // Run until done is seen. mode 0: ready=1, 1: toggling, 2: random, 3: random with start
  // re-pulsed throughout the run. chain drives start in the done cycle.
  task automatic run(input int mode, input bit chain, input int budget);
    logic rdy;
    logic st;
    int   n;
    n = 0;
    saw_done = 1'b0;
    while (!saw_done && n < budget) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = cyc[0];
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      st = (mode == 3) ? m_busy : (chain && m_done);
      cycle(rdy, st, 1'b0);
      n++;
    end
    if (!saw_done) check("run_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0);
  endtask

  int t0;

  initial begin
    rst = 1'b1; start = 1'b0; w_ready = 1'b0;
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ren", mem_ren, 1'b0);
    check("rst_radd", mem_radd, 0);
    check("rst_valid", w_valid, 1'b0);
    check("rst_last", w_last, 1'b0);

    // Full-rate stream: done 33 cycles after start.
    done_count = 0;
    t0 = cyc;
    cycle(1'b1, 1'b1, 1'b0);
    run(0, 1'b0, 100);
    check("t1_done_time", done_cyc - t0, 33);
    idle(3);
    check("t1_done_count", done_count, 1);

    // Toggling backpressure.
    done_count = 0;
    cycle(1'b1, 1'b1, 1'b0);
    run(1, 1'b0, 200);
    idle(2);
    check("t2_done_count", done_count, 1);

    // Long stall right after start: only two reads may be outstanding.
    cycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b0);
    check("t3_reads", reads, 2);
    check("t3_valid", w_valid, 1'b1);
    check("t3_data", w_data, 16'h1000);
    run(0, 1'b0, 100);
    idle(2);

    // Start re-pulsed during FETCH and DRAIN with random ready.
    done_count = 0;
    cycle(1'b1, 1'b1, 1'b0);
    run(3, 1'b0, 400);
    idle(3);
    check("t4_done_count", done_count, 1);

    // Reset in the middle of a run.
    done_count = 0;
    cycle(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0);
    check("t5_busy", busy, 1'b0);
    check("t5_ren", mem_ren, 1'b0);
    check("t5_radd", mem_radd, 0);
    check("t5_valid", w_valid, 1'b0);
    check("t5_last", w_last, 1'b0);
    idle(4);
    check("t5_no_done", done_count, 0);
    cycle(1'b1, 1'b1, 1'b0);
    run(2, 1'b0, 400);
    idle(2);
    check("t5_done_count", done_count, 1);

    // Back-to-back runs: next start in the done cycle.
    done_count = 0;
    cycle(1'b1, 1'b1, 1'b0);
    run(0, 1'b1, 100);
    check("t6_restart_busy", int'(m_busy), 1);
    run(2, 1'b0, 400);
    idle(3);
    check("t6_done_count", done_count, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
